rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one resource (e.g. the pr_encode output path) among N requesters.
//   It samples the req vector and holds one grant at a time, so no requester is starved.

---
 rtl/rr_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant among N requesters, rotating
// priority pointer, and a hold limit that forces the grant onward when others wait.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld
);

  localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic           r_state;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_gnt_vld;
  logic [IDW-1:0] r_ptr;
  logic [HCW-1:0] r_hold;

  logic           w_state_n;
  logic [IDW-1:0] w_gnt_id_n;
  logic           w_gnt_vld_n;
  logic [IDW-1:0] w_ptr_n;
  logic [HCW-1:0] w_hold_n;
  logic [N-1:0]   w_other;
  logic [IDW-1:0] w_nxt;
  logic           w_release;
  logic           w_preempt;

  // First set bit of v scanning upward from s, wrapping mod N.
  function automatic logic [IDW-1:0] f_search(input logic [N-1:0] v, input logic [IDW-1:0] s);
    logic [IDW-1:0] id;
    logic           found;
    id    = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(s) + k) % N;
      if (!found && v[idx]) begin
        found = 1'b1;
        id    = IDW'(idx);
      end
    end
    return id;
  endfunction

  // r_gnt is one-hot of the owner, so masking with it removes the owner from the search.
  assign w_other   = req & ~r_gnt;
  assign w_nxt     = IDW'((int'(r_gnt_id) + 1) % N);
  assign w_release = !req[r_gnt_id];
  assign w_preempt = (MAX_HOLD != 0) && (r_hold == HOLD_LAST) && (|w_other);

  always_comb begin
    w_state_n   = r_state;
    w_gnt_id_n  = r_gnt_id;
    w_gnt_vld_n = r_gnt_vld;
    w_ptr_n     = r_ptr;
    w_hold_n    = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_gnt_id_n  = f_search(req, r_ptr);
          w_gnt_vld_n = 1'b1;
          w_hold_n    = '0;
          w_state_n   = ST_GRANT;
        end
      end
      default: begin
        if (w_release) begin
          w_ptr_n = w_nxt;
          if (|w_other) begin
            w_gnt_id_n = f_search(w_other, w_nxt);
            w_hold_n   = '0;
          end else begin
            w_gnt_vld_n = 1'b0;
            w_state_n   = ST_IDLE;
          end
        end else if (w_preempt) begin
          w_gnt_id_n = f_search(w_other, w_nxt);
          w_ptr_n    = w_nxt;
          w_hold_n   = '0;
        end else if (MAX_HOLD != 0 && r_hold != HOLD_LAST) begin
          w_hold_n = r_hold + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_gnt     <= w_gnt_vld_n ? (ONE << w_gnt_id_n) : '0;
      r_gnt_id  <= w_gnt_id_n;
      r_gnt_vld <= w_gnt_vld_n;
      r_ptr     <= w_ptr_n;
      r_hold    <= w_hold_n;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboarded bench for rr_arbiter: a reference model predicts the grant after each
// edge, and a negedge monitor pops and compares against the DUT.
module tb_rr_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int MAXH = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;

  typedef struct {
    logic [N-1:0] g;
    int           id;
    bit           vld;
    string        tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state: owner index (-1 when idle), priority pointer, cycles held.
  int   m_own  = -1;
  int   m_ptr  = 0;
  int   m_held = 0;

  rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld)
  );

  always #5 clk = ~clk;

  function automatic int search(input logic [N-1:0] v, input int s);
    for (int k = 0; k < N; k++)
      if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r);
    logic [N-1:0] other;
    int nxt;
    if (m_own < 0) begin
      if (r != 0) begin
        m_own  = search(r, m_ptr);
        m_held = 1;
      end
    end else begin
      other = r;
      other[m_own] = 1'b0;
      nxt = (m_own + 1) % N;
      if (!r[m_own]) begin
        m_ptr = nxt;
        m_own = (other != 0) ? search(other, nxt) : -1;
        m_held = 1;
      end else if (MAXH != 0 && m_held >= MAXH && other != 0) begin
        m_own  = search(other, nxt);
        m_ptr  = nxt;
        m_held = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  // Drive req mid-cycle, let one edge pass, push the predicted response.
  task automatic step(input logic [N-1:0] r, input string tag);
    exp_t e;
    req = r;
    @(posedge clk);
    model_edge(r);
    e.vld = (m_own >= 0);
    e.id  = e.vld ? m_own : 0;
    e.g   = e.vld ? (4'b0001 << m_own) : '0;
    e.tag = tag;
    q.push_back(e);
    #1;
  endtask

  task automatic check_clear(input string tag);
    tests++;
    if (gnt !== '0 || gnt_vld !== 1'b0 || gnt_id !== '0) begin
      fails++;
      $display("FAIL %s: got gnt=%b id=%0d vld=%b, want all zero", tag, gnt, gnt_id, gnt_vld);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (gnt !== e.g || gnt_vld !== e.vld || (e.vld && gnt_id !== IDW'(e.id))) begin
        fails++;
        $display("FAIL %s: got gnt=%b id=%0d vld=%b, want gnt=%b id=%0d vld=%b",
                 e.tag, gnt, gnt_id, gnt_vld, e.g, e.id, e.vld);
      end
      tests++;
      if (gnt_vld && gnt !== (4'b0001 << gnt_id)) begin
        fails++;
        $display("FAIL %s onehot: got gnt=%b id=%0d, want gnt[id] only", e.tag, gnt, gnt_id);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    #1 check_clear("reset_async");
    repeat (2) @(posedge clk);
    check_clear("reset_hold");
    #1 rst_n = 1'b1;

    step(4'b1111, "t1_first");
    step(4'b0000, "t1_drop");
    step(4'b0000, "t1_idle");

    step(4'b0100, "t2_lone2");
    step(4'b0100, "t2_keep2");
    step(4'b0000, "t2_release");
    step(4'b0001, "t2_wrap");
    step(4'b0000, "t2_drop0");
    step(4'b0000, "t2_idle");

    step(4'b1111, "t3_start");
    for (int i = 0; i < 4; i++) begin
      step(4'b1111 & ~(4'b0001 << m_own), "t3_rotate");
      step(4'b1111, "t3_hold");
    end
    step(4'b0000, "t3_end");
    step(4'b0000, "t3_idle");

    step(4'b0100, "t4_own2");
    step(4'b0000, "t4_rel2");
    step(4'b1001, "t4_ptr3");
    step(4'b1001, "t4_keep3");
    step(4'b0001, "t4_rel3");
    step(4'b0000, "t4_end");

    for (int i = 0; i < 26; i++) step(4'b0011, "t5_hold");
    step(4'b0000, "t5_drop");
    for (int i = 0; i < 20; i++) step(4'b0001, "t5_lone");

    // Asynchronous reset pulse in the middle of a grant, entirely between edges.
    q.delete();
    rst_n = 1'b0;
    #1 check_clear("t6_async");
    #1 rst_n = 1'b1;
    m_own = -1; m_ptr = 0; m_held = 0;
    step(4'b1110, "t6_ptr0");
    step(4'b0000, "t6_drop");

    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if (m_own >= 0 && $urandom_range(0, 3) != 0) r[m_own] = 1'b1;
      step(r, "rand");
    end
    step(4'b0000, "final");

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses never checked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
